// File: rtl/data_memory_dma.sv
// Block-transfer engine for the single-port data memory: forward byte copy
// (read then write per byte) or constant fill (one write per byte).
module data_memory_dma #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_start,
    input  logic              in_mode,
    input  logic [ADDR_W-1:0] in_src_addr,
    input  logic [ADDR_W-1:0] in_dst_addr,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [DATA_W-1:0] in_fill_data,
    output logic              out_busy,
    output logic              out_done,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_mem_write_en,
    output logic [DATA_W-1:0] out_mem_data,
    input  logic [DATA_W-1:0] in_mem_data
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_mode;
    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [LEN_W-1:0]  r_count;
    logic [DATA_W-1:0] r_fill;
    logic [LEN_W-1:0]  w_len_clamped;

    assign w_len_clamped = (in_len > MAX_LEN) ? MAX_LEN : in_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_count   <= '0;
            r_fill    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_mode    <= in_mode;
                        r_src_ptr <= in_src_addr;
                        r_dst_ptr <= in_dst_addr;
                        r_count   <= w_len_clamped;
                        r_fill    <= in_fill_data;
                        if (w_len_clamped == '0)
                            r_state <= S_DONE;
                        else
                            r_state <= in_mode ? S_WR : S_RD;
                    end
                end
                S_RD: r_state <= S_WR;
                S_WR: begin
                    r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
                    if (!r_mode)
                        r_src_ptr <= r_src_ptr + ADDR_W'(1);
                    r_count <= r_count - LEN_W'(1);
                    if (r_count == LEN_W'(1))
                        r_state <= S_DONE;
                    else
                        r_state <= r_mode ? S_WR : S_RD;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write enable is masked by reset so the edge that aborts a transfer
    // cannot also commit one more byte into memory.
    always_comb begin
        out_busy         = (r_state != S_IDLE);
        out_done         = (r_state == S_DONE);
        out_mem_addr     = '0;
        out_mem_write_en = 1'b0;
        out_mem_data     = '0;
        case (r_state)
            S_RD: out_mem_addr = r_src_ptr;
            S_WR: begin
                out_mem_addr     = r_dst_ptr;
                out_mem_write_en = !rst;
                out_mem_data     = r_mode ? r_fill : in_mem_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_data_memory_dma.sv
// Directed bench for data_memory_dma with a registered-read 1024x8 memory model.
module tb_data_memory_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_start = 1'b0;
    logic        in_mode = 1'b0;
    logic [9:0]  in_src_addr = '0;
    logic [9:0]  in_dst_addr = '0;
    logic [10:0] in_len = '0;
    logic [7:0]  in_fill_data = '0;
    logic        out_busy, out_done, out_mem_write_en;
    logic [9:0]  out_mem_addr;
    logic [7:0]  out_mem_data;
    logic [7:0]  in_mem_data;

    logic [7:0]  mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [7:0]  pre_data = '0;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    data_memory_dma #(.ADDR_W(10), .DATA_W(8), .LEN_W(11)) dut (
        .clk(clk), .rst(rst), .in_start(in_start), .in_mode(in_mode),
        .in_src_addr(in_src_addr), .in_dst_addr(in_dst_addr), .in_len(in_len),
        .in_fill_data(in_fill_data), .out_busy(out_busy), .out_done(out_done),
        .out_mem_addr(out_mem_addr), .out_mem_write_en(out_mem_write_en),
        .out_mem_data(out_mem_data), .in_mem_data(in_mem_data)
    );

    // Memory model: registered read, write port shared with a preload path.
    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (out_mem_write_en)
            mem[out_mem_addr] <= out_mem_data;
        in_mem_data <= mem[out_mem_addr];
    end

    always @(negedge clk) begin
        if (out_mem_write_en) wr_cnt <= wr_cnt + 1;
        if (out_done) done_cnt <= done_cnt + 1;
    end

    task automatic preload(input logic [9:0] addr, input logic [7:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = addr; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Operands are scrambled right after the start edge; the engine must ignore that.
    task automatic apply_start(input logic mode, input logic [9:0] src, input logic [9:0] dst,
                               input logic [10:0] len, input logic [7:0] fill, input bit hold);
        @(negedge clk);
        in_mode = mode; in_src_addr = src; in_dst_addr = dst; in_len = len; in_fill_data = fill;
        in_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) in_start = 1'b0;
        in_mode = ~mode; in_src_addr = src ^ 10'h155; in_dst_addr = dst ^ 10'h2AA;
        in_len = 11'd7; in_fill_data = ~fill;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_start = 1'b1; in_mode = 1'b1; in_dst_addr = 10'h123; in_len = 11'd5; in_fill_data = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if (out_busy !== 1'b0 || out_done !== 1'b0 || out_mem_addr !== 10'h0 ||
            out_mem_write_en !== 1'b0 || out_mem_data !== 8'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b addr=%h we=%b data=%h, need all zero",
                     out_busy, out_done, out_mem_addr, out_mem_write_en, out_mem_data);
        end
        in_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b, need 0", out_busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_fill();
        logic       e_we, e_done;
        logic [9:0] e_addr;
        logic [7:0] e_data;
        preload(10'h014, 8'h77);
        apply_start(1'b1, 10'h0, 10'h010, 11'd4, 8'hA5, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            e_we   = (k <= 4);
            e_addr = (k <= 4) ? 10'h010 + 10'(k - 1) : 10'h0;
            e_data = (k <= 4) ? 8'hA5 : 8'h00;
            e_done = (k == 5);
            checks++;
            if (out_mem_write_en !== e_we || out_mem_addr !== e_addr || out_mem_data !== e_data ||
                out_done !== e_done || out_busy !== 1'b1) begin
                errors++;
                $display("FAIL fill_cyc%0d: we=%b addr=%h data=%h done=%b busy=%b, need we=%b addr=%h data=%h done=%b busy=1",
                         k, out_mem_write_en, out_mem_addr, out_mem_data, out_done, out_busy,
                         e_we, e_addr, e_data, e_done);
            end
        end
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b0 || mem[10'h013] !== 8'hA5 || mem[10'h014] !== 8'h77) begin
            errors++;
            $display("FAIL fill_end: busy=%b mem13=%h mem14=%h, need busy=0 mem13=a5 mem14=77",
                     out_busy, mem[10'h013], mem[10'h014]);
        end
        $display("test_fill: dst=010 len=4 fill=a5 done");
    endtask

    task automatic test_copy();
        logic [7:0] vals [3];
        logic       e_we;
        logic [9:0] e_addr;
        logic [7:0] e_data;
        int         j;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) preload(10'h100 + 10'(i), vals[i]);
        apply_start(1'b0, 10'h100, 10'h200, 11'd3, 8'h00, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            j = (k - 1) / 2;
            if (k == 7) begin
                e_we = 1'b0; e_addr = 10'h0; e_data = 8'h0;
            end else if (k % 2 == 1) begin
                e_we = 1'b0; e_addr = 10'h100 + 10'(j); e_data = 8'h0;
            end else begin
                e_we = 1'b1; e_addr = 10'h200 + 10'(j); e_data = vals[j];
            end
            checks++;
            if (out_mem_write_en !== e_we || out_mem_addr !== e_addr || out_mem_data !== e_data ||
                out_done !== (k == 7)) begin
                errors++;
                $display("FAIL copy_cyc%0d: we=%b addr=%h data=%h done=%b, need we=%b addr=%h data=%h done=%b",
                         k, out_mem_write_en, out_mem_addr, out_mem_data, out_done,
                         e_we, e_addr, e_data, (k == 7));
            end
        end
        @(negedge clk);
        checks++;
        if (mem[10'h200] !== 8'h11 || mem[10'h201] !== 8'h22 || mem[10'h202] !== 8'h33) begin
            errors++;
            $display("FAIL copy_mem: %h %h %h, need 11 22 33", mem[10'h200], mem[10'h201], mem[10'h202]);
        end
        $display("test_copy: src=100 dst=200 len=3 done");
    endtask

    task automatic test_wrap();
        logic [9:0] e_addr;
        apply_start(1'b1, 10'h0, 10'h3FE, 11'd4, 8'h5C, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e_addr = 10'h3FE + 10'(k - 1);
            checks++;
            if (out_mem_addr !== e_addr || out_mem_write_en !== 1'b1) begin
                errors++;
                $display("FAIL wrap_fill_cyc%0d: addr=%h we=%b, need addr=%h we=1",
                         k, out_mem_addr, out_mem_write_en, e_addr);
            end
        end
        repeat (2) @(negedge clk);
        apply_start(1'b0, 10'h3FF, 10'h050, 11'd2, 8'h00, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1 || k == 3) begin
                e_addr = (k == 1) ? 10'h3FF : 10'h000;
                checks++;
                if (out_mem_addr !== e_addr || out_mem_write_en !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_copy_rd%0d: addr=%h we=%b, need addr=%h we=0",
                             k, out_mem_addr, out_mem_write_en, e_addr);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (mem[10'h000] !== 8'h5C || mem[10'h001] !== 8'h5C || mem[10'h050] !== 8'h5C || mem[10'h051] !== 8'h5C) begin
            errors++;
            $display("FAIL wrap_mem: m000=%h m001=%h m050=%h m051=%h, need all 5c",
                     mem[10'h000], mem[10'h001], mem[10'h050], mem[10'h051]);
        end
        $display("test_wrap: fill 3fe..001, copy 3ff,000 -> 050 done");
    endtask

    task automatic test_len0_and_busy_start();
        int wr0, dn0;
        wr0 = wr_cnt; dn0 = done_cnt;
        apply_start(1'b1, 10'h0, 10'h040, 11'd0, 8'h99, 1'b1);
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b1 || out_done !== 1'b1 || out_mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL len0_cyc1: busy=%b done=%b we=%b, need 1 1 0", out_busy, out_done, out_mem_write_en);
        end
        in_start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (out_busy !== 1'b0 || out_done !== 1'b0) begin
                errors++;
                $display("FAIL len0_after: busy=%b done=%b, need 0 0", out_busy, out_done);
            end
        end
        checks++;
        if (wr_cnt - wr0 !== 0 || done_cnt - dn0 !== 1) begin
            errors++;
            $display("FAIL len0_counts: writes=%0d dones=%0d, need 0 1", wr_cnt - wr0, done_cnt - dn0);
        end
        // Start stays high through the whole fill; only the first edge may count.
        wr0 = wr_cnt; dn0 = done_cnt;
        apply_start(1'b1, 10'h0, 10'h060, 11'd3, 8'h4D, 1'b1);
        repeat (4) @(negedge clk);
        in_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt - wr0 !== 3 || done_cnt - dn0 !== 1 || mem[10'h062] !== 8'h4D) begin
            errors++;
            $display("FAIL busy_start: writes=%0d dones=%0d mem062=%h, need 3 1 4d",
                     wr_cnt - wr0, done_cnt - dn0, mem[10'h062]);
        end
        $display("test_len0_and_busy_start done");
    endtask

    task automatic test_overlap();
        for (int i = 0; i < 4; i++) preload(10'(i), 8'(i + 1));
        apply_start(1'b0, 10'h000, 10'h001, 11'd3, 8'h00, 1'b0);
        repeat (9) @(negedge clk);
        checks++;
        if (mem[0] !== 8'h01 || mem[1] !== 8'h01 || mem[2] !== 8'h01 || mem[3] !== 8'h01) begin
            errors++;
            $display("FAIL overlap: %h %h %h %h, need 01 01 01 01", mem[0], mem[1], mem[2], mem[3]);
        end
        $display("test_overlap: src=0 dst=1 len=3 done");
    endtask

    task automatic test_reset_mid();
        int wr0, dn0;
        for (int i = 0; i < 4; i++) preload(10'h080 + 10'(i), 8'h00);
        wr0 = wr_cnt; dn0 = done_cnt;
        apply_start(1'b1, 10'h0, 10'h080, 11'd8, 8'hEE, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_mem_write_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_we: we=%b, need 0", out_mem_write_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b0 || out_mem_write_en !== 1'b0 || out_done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: busy=%b we=%b done=%b, need 0 0 0", out_busy, out_mem_write_en, out_done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt - wr0 !== 2 || done_cnt - dn0 !== 0 || mem[10'h081] !== 8'hEE || mem[10'h082] !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_counts: writes=%0d dones=%0d m081=%h m082=%h, need 2 0 ee 00",
                     wr_cnt - wr0, done_cnt - dn0, mem[10'h081], mem[10'h082]);
        end
        dn0 = done_cnt;
        apply_start(1'b1, 10'h0, 10'h090, 11'd2, 8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - dn0 !== 1 || mem[10'h090] !== 8'h3C || mem[10'h091] !== 8'h3C) begin
            errors++;
            $display("FAIL rstmid_restart: dones=%0d m090=%h m091=%h, need 1 3c 3c",
                     done_cnt - dn0, mem[10'h090], mem[10'h091]);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_wrap();
        test_len0_and_busy_start();
        test_overlap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
